// File: rtl/oob_dev.sv
// Device-side SATA OOB responder: answers COMRESET with COMINIT and COMWAKE with
// COMWAKE, exchanges ALIGN, sends one SYNC and then passes link data through.
module oob_dev #(
    parameter logic [19:0] RETRY_TIMEOUT = 20'd66000,
    parameter logic [7:0]  WAKE_GAP      = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gtx_ready,
    input  logic        rxcominitdet_in,
    input  logic        rxcomwakedet_in,
    input  logic        rxelecidle_in,
    input  logic        rxbyteisaligned,
    input  logic [31:0] rxdata_in,
    input  logic [3:0]  rxcharisk_in,
    input  logic [31:0] txdata_in,
    input  logic [3:0]  txcharisk_in,
    output logic        txcominit,
    output logic        txcomwake,
    output logic        txelecidle,
    output logic [31:0] txdata_out,
    output logic [3:0]  txcharisk_out,
    output logic [31:0] rxdata_out,
    output logic [3:0]  rxcharisk_out,
    output logic        phy_ready
);

    localparam int unsigned TIMER_W = 20;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned K_W     = 4;

    localparam logic [DATA_W-1:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [DATA_W-1:0] SYNC_DW  = 32'hB5B5957C;
    localparam logic [K_W-1:0]    K_FIRST  = 4'b0001;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_COMRESET,
        SEND_COMINIT,
        WAIT_COMWAKE,
        SEND_COMWAKE,
        WAKE_END,
        SEND_ALIGN,
        SEND_SYNC,
        READY
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic               timer_hit;
    logic               gap_done;
    logic               host_align;
    logic               counting;

    // Next-state selection: transceiver loss first, then a re-issued COMRESET.
    always_comb begin
        state_d    = state_q;
        timer_hit  = (timer_q >= RETRY_TIMEOUT);
        gap_done   = (timer_q >= TIMER_W'(WAKE_GAP));
        host_align = rxbyteisaligned && (rxdata_in == ALIGN_DW) && (rxcharisk_in == K_FIRST);
        counting   = (state_q == WAIT_COMWAKE) || (state_q == WAKE_END) || (state_q == SEND_ALIGN);

        if (!gtx_ready) begin
            state_d = IDLE;
        end else if (rxcominitdet_in && (state_q != IDLE)) begin
            state_d = SEND_COMINIT;
        end else begin
            case (state_q)
                IDLE:          state_d = WAIT_COMRESET;
                WAIT_COMRESET: state_d = state_q;
                SEND_COMINIT:  state_d = WAIT_COMWAKE;
                WAIT_COMWAKE: begin
                    if (rxcomwakedet_in) state_d = SEND_COMWAKE;
                    else if (timer_hit)  state_d = WAIT_COMRESET;
                end
                SEND_COMWAKE:  state_d = WAKE_END;
                WAKE_END: begin
                    if (gap_done && !rxelecidle_in) state_d = SEND_ALIGN;
                end
                SEND_ALIGN: begin
                    if (host_align)     state_d = SEND_SYNC;
                    else if (timer_hit) state_d = WAIT_COMRESET;
                end
                SEND_SYNC:     state_d = READY;
                READY:         state_d = state_q;
                default:       state_d = IDLE;
            endcase
        end
    end

    // State, timer and registered outputs; control outputs track the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            txcominit     <= 1'b0;
            txcomwake     <= 1'b0;
            txelecidle    <= 1'b1;
            txdata_out    <= '0;
            txcharisk_out <= '0;
            rxdata_out    <= '0;
            rxcharisk_out <= '0;
            phy_ready     <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q)
                timer_q <= '0;
            else if (counting && (timer_q != '1))
                timer_q <= timer_q + TIMER_W'(1);

            txcominit  <= (state_d == SEND_COMINIT);
            txcomwake  <= (state_d == SEND_COMWAKE);
            phy_ready  <= (state_d == READY);
            txelecidle <= !((state_d == SEND_ALIGN) || (state_d == SEND_SYNC) || (state_d == READY));

            // TX payload is chosen by the state of the previous cycle.
            if (!gtx_ready) begin
                txdata_out    <= '0;
                txcharisk_out <= '0;
            end else begin
                case (state_q)
                    SEND_ALIGN: begin
                        txdata_out    <= ALIGN_DW;
                        txcharisk_out <= K_FIRST;
                    end
                    SEND_SYNC: begin
                        txdata_out    <= SYNC_DW;
                        txcharisk_out <= K_FIRST;
                    end
                    READY: begin
                        txdata_out    <= txdata_in;
                        txcharisk_out <= txcharisk_in;
                    end
                    default: begin
                        txdata_out    <= '0;
                        txcharisk_out <= '0;
                    end
                endcase
            end

            rxdata_out    <= rxdata_in;
            rxcharisk_out <= rxcharisk_in;
        end
    end

endmodule

// File: tb/tb_oob_dev.sv
// Scenario bench for oob_dev: handshake, timeouts, re-COMRESET, data path and resets.
module tb_oob_dev;

    localparam int unsigned RT = 300;
    localparam int unsigned G  = 16;
    localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_DW  = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        rst;
    logic        gtx_ready;
    logic        rxcominitdet_in;
    logic        rxcomwakedet_in;
    logic        rxelecidle_in;
    logic        rxbyteisaligned;
    logic [31:0] rxdata_in;
    logic [3:0]  rxcharisk_in;
    logic [31:0] txdata_in;
    logic [3:0]  txcharisk_in;
    logic        txcominit;
    logic        txcomwake;
    logic        txelecidle;
    logic [31:0] txdata_out;
    logic [3:0]  txcharisk_out;
    logic [31:0] rxdata_out;
    logic [3:0]  rxcharisk_out;
    logic        phy_ready;

    int checks = 0;
    int errors = 0;
    int cominit_cnt = 0;
    int comwake_cnt = 0;
    int sync_cnt = 0;

    oob_dev #(.RETRY_TIMEOUT(20'd300), .WAKE_GAP(8'd16)) dut (
        .clk(clk), .rst(rst), .gtx_ready(gtx_ready),
        .rxcominitdet_in(rxcominitdet_in), .rxcomwakedet_in(rxcomwakedet_in),
        .rxelecidle_in(rxelecidle_in), .rxbyteisaligned(rxbyteisaligned),
        .rxdata_in(rxdata_in), .rxcharisk_in(rxcharisk_in),
        .txdata_in(txdata_in), .txcharisk_in(txcharisk_in),
        .txcominit(txcominit), .txcomwake(txcomwake), .txelecidle(txelecidle),
        .txdata_out(txdata_out), .txcharisk_out(txcharisk_out),
        .rxdata_out(rxdata_out), .rxcharisk_out(rxcharisk_out),
        .phy_ready(phy_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Pulse/word counters and the COMINIT/COMWAKE exclusivity rule, sampled mid-cycle.
    always @(negedge clk) begin
        if (txcominit) cominit_cnt++;
        if (txcomwake) comwake_cnt++;
        if (txdata_out == SYNC_DW && txcharisk_out == 4'b0001) sync_cnt++;
        checks++;
        if (txcominit && txcomwake) begin
            errors++;
            $display("FAIL cominit_comwake_exclusive: both asserted at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        rxcominitdet_in = 1'b0;
        rxcomwakedet_in = 1'b0;
        rxelecidle_in   = 1'b1;
        rxbyteisaligned = 1'b0;
        rxdata_in       = '0;
        rxcharisk_in    = '0;
        txdata_in       = '0;
        txcharisk_in    = '0;
    endtask

    // Full handshake from WAIT_COMRESET (or from SEND_COMINIT when after_cominit=1) to READY.
    task automatic run_to_ready(input bit after_cominit, input bit bad_align);
        int bad;
        quiet_inputs();
        if (!after_cominit) begin
            cominit_cnt = 0; comwake_cnt = 0; sync_cnt = 0;
            rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
            checks++;
            if (txcominit !== 1'b1 || txelecidle !== 1'b1) begin
                errors++; $display("FAIL cominit_pulse: txcominit=%b txelecidle=%b want 1 1", txcominit, txelecidle);
            end
        end
        tick();
        checks++;
        if (txcominit !== 1'b0 || txelecidle !== 1'b1) begin
            errors++; $display("FAIL cominit_one_cycle: txcominit=%b txelecidle=%b want 0 1", txcominit, txelecidle);
        end
        repeat (9) tick();
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        checks++;
        if (txcomwake !== 1'b1) begin
            errors++; $display("FAIL comwake_pulse: txcomwake=%b want 1", txcomwake);
        end
        tick();
        checks++;
        if (txcomwake !== 1'b0 || txelecidle !== 1'b1) begin
            errors++; $display("FAIL comwake_one_cycle: txcomwake=%b txelecidle=%b want 0 1", txcomwake, txelecidle);
        end
        bad = 0;
        repeat (100) begin
            tick();
            if (txelecidle !== 1'b1 || phy_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL wake_end_hold: %0d cycles left idle early, want 0", bad);
        end
        rxelecidle_in = 1'b0; tick();
        checks++;
        if (txelecidle !== 1'b0 || txdata_out !== 32'h0) begin
            errors++; $display("FAIL align_entry: txelecidle=%b txdata_out=%h want 0 00000000", txelecidle, txdata_out);
        end
        tick();
        checks++;
        if (txdata_out !== ALIGN_DW || txcharisk_out !== 4'b0001) begin
            errors++; $display("FAIL align_tx: txdata_out=%h k=%b want %h 0001", txdata_out, txcharisk_out, ALIGN_DW);
        end
        if (bad_align) begin
            bad = 0;
            rxdata_in = ALIGN_DW; rxbyteisaligned = 1'b1; rxcharisk_in = 4'b0000;
            repeat (5) begin
                tick();
                if (txdata_out !== ALIGN_DW || phy_ready !== 1'b0) bad++;
            end
            rxbyteisaligned = 1'b0; rxcharisk_in = 4'b0001;
            repeat (5) begin
                tick();
                if (txdata_out !== ALIGN_DW || phy_ready !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL align_unqualified: %0d cycles left SEND_ALIGN, want 0", bad);
            end
        end
        rxdata_in = ALIGN_DW; rxcharisk_in = 4'b0001; rxbyteisaligned = 1'b1;
        tick();
        rxdata_in = $urandom & 32'h00FF_FFFF; rxcharisk_in = 4'b0000;
        checks++;
        if (phy_ready !== 1'b0 || txdata_out !== ALIGN_DW) begin
            errors++; $display("FAIL sync_state: phy_ready=%b txdata_out=%h want 0 %h", phy_ready, txdata_out, ALIGN_DW);
        end
        tick();
        checks++;
        if (phy_ready !== 1'b1 || txdata_out !== SYNC_DW || txcharisk_out !== 4'b0001 || txelecidle !== 1'b0) begin
            errors++; $display("FAIL ready_entry: phy_ready=%b txdata_out=%h k=%b txelecidle=%b want 1 %h 0001 0",
                               phy_ready, txdata_out, txcharisk_out, txelecidle, SYNC_DW);
        end
        tick();
        checks++;
        if (txdata_out !== 32'h0 || phy_ready !== 1'b1) begin
            errors++; $display("FAIL ready_passthrough_idle: txdata_out=%h phy_ready=%b want 00000000 1", txdata_out, phy_ready);
        end
        checks++;
        if (cominit_cnt != 1 || comwake_cnt != 1 || sync_cnt != 1) begin
            errors++; $display("FAIL pulse_counts: cominit=%0d comwake=%0d sync=%0d want 1 1 1", cominit_cnt, comwake_cnt, sync_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; gtx_ready = 1'b0;
        quiet_inputs();
        rxdata_in = $urandom; rxcharisk_in = 4'hF; rxcominitdet_in = 1'b1;
        repeat (3) tick();
        checks++;
        if (txcominit !== 1'b0 || txcomwake !== 1'b0 || txelecidle !== 1'b1 || phy_ready !== 1'b0 ||
            txdata_out !== 32'h0 || txcharisk_out !== 4'h0 || rxdata_out !== 32'h0 || rxcharisk_out !== 4'h0) begin
            errors++; $display("FAIL reset_values: cominit=%b comwake=%b elecidle=%b ready=%b tx=%h/%h rx=%h/%h want 0 0 1 0 0/0 0/0",
                               txcominit, txcomwake, txelecidle, phy_ready, txdata_out, txcharisk_out, rxdata_out, rxcharisk_out);
        end
        quiet_inputs();
        rst = 1'b1; gtx_ready = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        run_to_ready(1'b0, 1'b0);
    endtask

    task automatic test_ready_data();
        logic [31:0] etx, erx;
        logic [3:0]  etk, erk;
        int bad = 0;
        for (int i = 0; i < 20; i++) begin
            etx = (i == 0) ? 32'hDEADBEEF : $urandom;
            erx = $urandom;
            etk = 4'($urandom);
            erk = 4'($urandom);
            txdata_in = etx; txcharisk_in = etk; rxdata_in = erx; rxcharisk_in = erk;
            tick();
            if (txdata_out !== etx || txcharisk_out !== etk || rxdata_out !== erx || rxcharisk_out !== erk) begin
                bad++;
                if (bad == 1)
                    $display("FAIL ready_data: tx=%h/%h rx=%h/%h want %h/%h %h/%h",
                             txdata_out, txcharisk_out, rxdata_out, rxcharisk_out, etx, etk, erx, erk);
            end
        end
        checks++;
        if (bad != 0) errors++;
        quiet_inputs();
        rxelecidle_in = 1'b0;
    endtask

    task automatic test_gtx_drop();
        int bad = 0;
        txdata_in = 32'hA5A5_0001; txcharisk_in = 4'b0011;
        gtx_ready = 1'b0;
        tick();
        checks++;
        if (phy_ready !== 1'b0 || txelecidle !== 1'b1 || txdata_out !== 32'h0 || txcharisk_out !== 4'h0 ||
            txcominit !== 1'b0 || txcomwake !== 1'b0) begin
            errors++; $display("FAIL gtx_drop: ready=%b elecidle=%b tx=%h/%h cominit=%b comwake=%b want 0 1 0/0 0 0",
                               phy_ready, txelecidle, txdata_out, txcharisk_out, txcominit, txcomwake);
        end
        rxcominitdet_in = 1'b1;
        repeat (3) begin
            tick();
            if (txcominit !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL gtx_low_ignores_comreset: %0d cominit pulses, want 0", bad);
        end
        rxcominitdet_in = 1'b0;
        gtx_ready = 1'b1;
        tick();
        run_to_ready(1'b0, 1'b0);
    endtask

    task automatic test_comreset_in_ready();
        cominit_cnt = 0; comwake_cnt = 0; sync_cnt = 0;
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        checks++;
        if (phy_ready !== 1'b0 || txcominit !== 1'b1 || txelecidle !== 1'b1) begin
            errors++; $display("FAIL comreset_in_ready: phy_ready=%b txcominit=%b txelecidle=%b want 0 1 1",
                               phy_ready, txcominit, txelecidle);
        end
        run_to_ready(1'b1, 1'b1);
    endtask

    task automatic test_wake_gap();
        int cnt = 0;
        quiet_inputs();
        rxelecidle_in = 1'b0;
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        tick();
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        tick();
        while (txelecidle === 1'b1 && cnt < int'(G) + 10) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt < int'(G) || cnt > int'(G) + 2) begin
            errors++; $display("FAIL wake_gap: left WAKE_END after %0d cycles, want %0d..%0d", cnt, G, G + 2);
        end
    endtask

    task automatic test_reset_mid_align();
        rxdata_in = $urandom | 32'h1; rxcharisk_in = 4'b1010;
        tick();
        checks++;
        if (txdata_out !== ALIGN_DW || txelecidle !== 1'b0) begin
            errors++; $display("FAIL align_before_reset: txdata_out=%h txelecidle=%b want %h 0", txdata_out, txelecidle, ALIGN_DW);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (txcominit !== 1'b0 || txcomwake !== 1'b0 || txelecidle !== 1'b1 || phy_ready !== 1'b0 ||
            txdata_out !== 32'h0 || txcharisk_out !== 4'h0 || rxdata_out !== 32'h0 || rxcharisk_out !== 4'h0) begin
            errors++; $display("FAIL async_reset: elecidle=%b ready=%b tx=%h/%h rx=%h/%h want 1 0 0/0 0/0",
                               txelecidle, phy_ready, txdata_out, txcharisk_out, rxdata_out, rxcharisk_out);
        end
        tick();
        quiet_inputs();
        rst = 1'b1;
        tick();
        repeat (4) tick();
        checks++;
        if (txcominit !== 1'b0 || txcomwake !== 1'b0 || txelecidle !== 1'b1 || txdata_out !== 32'h0) begin
            errors++; $display("FAIL after_reset_quiet: cominit=%b comwake=%b elecidle=%b tx=%h want 0 0 1 0",
                               txcominit, txcomwake, txelecidle, txdata_out);
        end
    endtask

    task automatic test_comwake_timeout();
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        checks++;
        if (txcominit !== 1'b1) begin
            errors++; $display("FAIL cominit_before_timeout: txcominit=%b want 1", txcominit);
        end
        tick();
        repeat (RT - 5) tick();
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        checks++;
        if (txcomwake !== 1'b1) begin
            errors++; $display("FAIL comwake_before_timeout: txcomwake=%b want 1", txcomwake);
        end
        tick();
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        checks++;
        if (txcominit !== 1'b1) begin
            errors++; $display("FAIL recomreset_wake_end: txcominit=%b want 1", txcominit);
        end
        tick();
        repeat (RT + 5) tick();
        rxcomwakedet_in = 1'b1; tick(); rxcomwakedet_in = 1'b0;
        tick();
        checks++;
        if (txcomwake !== 1'b0 || txelecidle !== 1'b1 || phy_ready !== 1'b0) begin
            errors++; $display("FAIL comwake_timeout: txcomwake=%b txelecidle=%b phy_ready=%b want 0 1 0",
                               txcomwake, txelecidle, phy_ready);
        end
        rxcominitdet_in = 1'b1; tick(); rxcominitdet_in = 1'b0;
        checks++;
        if (txcominit !== 1'b1) begin
            errors++; $display("FAIL cominit_after_timeout: txcominit=%b want 1", txcominit);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ready_data();
        test_gtx_drop();
        test_comreset_in_ready();
        test_wake_gap();
        test_reset_mid_align();
        test_comwake_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
